// File: rtl/isqrt_iter_fsm_pkg.sv
// Shared types and helpers for the iterative integer square-root responder.
package isqrt_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  localparam int X_W_DEF = 32;

  function automatic int lat(input int x_w, input int steps);
    return (x_w / 2) / steps + 1;
  endfunction

endpackage

// File: rtl/isqrt_iter_fsm_if.sv
// Valid-only request/result bundle between an initiator and the isqrt responder.
interface isqrt_iter_fsm_if #(
    parameter int X_W = 32
);

    logic               x_vld;
    logic [X_W-1:0]     x;
    logic               y_vld;
    logic [X_W/2-1:0]   y;

    modport master (
        output x_vld,
        output x,
        input  y_vld,
        input  y
    );

    modport slave (
        input  x_vld,
        input  x,
        output y_vld,
        output y
    );

endinterface

// File: rtl/isqrt_iter_fsm_step.sv
// One restoring radix-4 root digit: shift in a radicand pair, try {root,01}.
module isqrt_step #(
    parameter int Y_W = 16
) (
    input  logic [Y_W+1:0] rem_i,
    input  logic [Y_W-1:0] root_i,
    input  logic [1:0]     pair_i,
    output logic [Y_W+1:0] rem_o,
    output logic [Y_W-1:0] root_o
);

    logic [Y_W+1:0] rem_s;
    logic [Y_W+1:0] trial;
    logic           ge;

    // The remainder never exceeds 2*root, so its top bits and the root MSB
    // are zero on entry and dropping them in the shifts is lossless.
    logic unused_bits;
    assign unused_bits = ^{rem_i[Y_W+1:Y_W], root_i[Y_W-1]};

    assign rem_s  = {rem_i[Y_W-1:0], pair_i};
    assign trial  = {root_i, 2'b01};
    assign ge     = rem_s >= trial;
    assign rem_o  = ge ? rem_s - trial : rem_s;
    assign root_o = {root_i[Y_W-2:0], ge};

endmodule

// File: rtl/isqrt_iter_fsm.sv
// Iterative floor(sqrt(x)) responder, STEPS_PER_CLK root bits per clock.
// Optional ISQRT_ITER_FSM_OVERRUN_CHECK_EN adds a sticky overrun flag and assertions.
module isqrt_iter_fsm
  import isqrt_pkg::*;
#(
    parameter int X_W           = X_W_DEF,
    parameter int STEPS_PER_CLK = 1
) (
    input  logic             clk,
    input  logic             rst,
    isqrt_iter_fsm_if.slave  io,
    output logic             busy,
    output logic             overrun
);

    localparam int Y_W = X_W / 2;
    localparam int K   = Y_W / STEPS_PER_CLK;
    localparam int CW  = $clog2(K + 1);
    localparam int SH  = 2 * STEPS_PER_CLK;

    state_t          state;
    logic [X_W-1:0]  xr;
    logic [Y_W+1:0]  rem;
    logic [Y_W-1:0]  root;
    logic [CW-1:0]   cnt;

    logic [Y_W+1:0]  rem_c  [STEPS_PER_CLK+1];
    logic [Y_W-1:0]  root_c [STEPS_PER_CLK+1];

    assign rem_c[0]  = rem;
    assign root_c[0] = root;

    for (genvar g = 0; g < STEPS_PER_CLK; g++) begin : g_step
        isqrt_step #(
            .Y_W(Y_W)
        ) u_step (
            .rem_i  (rem_c[g]),
            .root_i (root_c[g]),
            .pair_i (xr[X_W-1-2*g -: 2]),
            .rem_o  (rem_c[g+1]),
            .root_o (root_c[g+1])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            xr       <= '0;
            rem      <= '0;
            root     <= '0;
            cnt      <= '0;
            busy     <= 1'b0;
            io.y_vld <= 1'b0;
            io.y     <= '0;
        end else begin
            io.y_vld <= 1'b0;
            unique case (state)
                IDLE, DONE: begin
                    if (io.x_vld) begin
                        xr    <= io.x;
                        rem   <= '0;
                        root  <= '0;
                        cnt   <= CW'(K - 1);
                        busy  <= 1'b1;
                        state <= CALC;
                    end else begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                CALC: begin
                    rem  <= rem_c[STEPS_PER_CLK];
                    root <= root_c[STEPS_PER_CLK];
                    xr   <= xr << SH;
                    if (cnt == '0) begin
                        io.y     <= root_c[STEPS_PER_CLK];
                        io.y_vld <= 1'b1;
                        busy     <= 1'b0;
                        state    <= DONE;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef ISQRT_ITER_FSM_OVERRUN_CHECK_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            overrun <= 1'b0;
        end else if (state == CALC && io.x_vld) begin
            overrun <= 1'b1;
        end
    end

`ifndef SYNTHESIS
    a_no_overrun: assert property (
        @(posedge clk) disable iff (rst)
        !(state == CALC && io.x_vld)
    );

    a_single_vld: assert property (
        @(posedge clk) disable iff (rst)
        io.y_vld |=> !io.y_vld
    );
`endif
`else
    assign overrun = 1'b0;
`endif

endmodule
